// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - request and instruction-memory bus of the instruction encoder/loader
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [5:0]        req_funct;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;
  logic              err_illegal;
  logic              mem_full;
  logic [ADDR_W:0]   words_done;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_funct, req_imm, req_target,
    output imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata, err_illegal, mem_full, words_done
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_funct, req_imm, req_target,
    input  imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata, err_illegal, mem_full, words_done
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs field-level MIPS requests into words, buffers them, streams them to imem
module instr_encoder_loader #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_encoder_loader_if.slave     bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [31:0]       fifo_mem [DEPTH];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   done_q;
  logic              full_q;
  logic              err_q;

  logic        fifo_empty;
  logic        fifo_full;
  logic        accept;
  logic        push;
  logic        pop;
  logic        legal;
  logic [31:0] enc_word;

  // Extra pointer bit separates full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign bus.req_ready   = !fifo_full && !full_q;
  assign bus.imem_we     = !fifo_empty && !full_q;
  assign bus.imem_wdata  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr[PW-1:0]];
  assign bus.imem_addr   = addr_q;
  assign bus.words_done  = done_q;
  assign bus.mem_full    = full_q;
  assign bus.err_illegal = err_q;

  assign accept = bus.req_valid && bus.req_ready;
  assign push   = accept && legal;
  assign pop    = bus.imem_we && bus.imem_ready;

  always_comb begin
    enc_word = 32'h0;
    legal    = 1'b1;
    case (bus.req_op)
      3'd0:    enc_word = {6'h23, bus.req_rs, bus.req_rt, bus.req_imm};
      3'd1:    enc_word = {6'h2B, bus.req_rs, bus.req_rt, bus.req_imm};
      3'd2:    enc_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'b0, bus.req_funct};
      3'd3:    enc_word = {6'h08, bus.req_rs, bus.req_rt, bus.req_imm};
      3'd4:    enc_word = {6'h02, bus.req_target};
      3'd5:    enc_word = {6'h04, bus.req_rs, bus.req_rt, bus.req_imm};
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      addr_q <= ADDR_W'(BASE_ADDR);
      done_q <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        done_q <= done_q + 1'b1;
        // The top address is the last one ever written; freeze rather than wrap.
        if (addr_q == LAST_ADDR) begin
          full_q <= 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end
endmodule
